ai_shot_seq: RTL and testbench

AI_SHOT_SEQ -- requirements
Module: ai_shot_seq

---
 rtl/ai_pkg.sv | 29 ++
 rtl/ai_shot_seq_if.sv | 14 +
 rtl/ai_wdata_mux.sv | 28 ++
 rtl/ai_shot_seq.sv | 143 ++++++++++++++
 tb/tb_ai_shot_seq.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ai_pkg.sv
// Shared types and constants for the AI shot sequencer and its density-engine
// register map.
package ai_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    GO,
    GAP,
    BUSY,
    RD,
    DONE
  } state_t;

  localparam logic [3:0] ADDR_GO     = 4'd0;
  localparam logic [3:0] ADDR_FIRED0 = 4'd1;
  localparam logic [3:0] ADDR_FIRED1 = 4'd2;
  localparam logic [3:0] ADDR_FIRED2 = 4'd3;
  localparam logic [3:0] ADDR_FIRED3 = 4'd4;
  localparam logic [3:0] ADDR_HITS0  = 4'd5;
  localparam logic [3:0] ADDR_HITS1  = 4'd6;
  localparam logic [3:0] ADDR_HITS2  = 4'd7;
  localparam logic [3:0] ADDR_HITS3  = 4'd8;
  localparam logic [3:0] ADDR_SHIPS  = 4'd9;

  localparam int         BOARD_CELLS = 100;
  localparam logic [6:0] NO_SHOT     = 7'd127;

endpackage

// File: rtl/ai_shot_seq_if.sv
// Register-bus link between the shot sequencer (master) and the density engine.
interface ai_shot_seq_if;
  logic [3:0]  av_addr;
  logic        av_write;
  logic        av_read;
  logic [31:0] av_wdata;
  logic [31:0] av_rdata;
  logic        av_waitreq;

  modport master (output av_addr, av_write, av_read, av_wdata,
                  input  av_rdata, av_waitreq);
  modport slave  (input  av_addr, av_write, av_read, av_wdata,
                  output av_rdata, av_waitreq);
endinterface

// File: rtl/ai_wdata_mux.sv
// Selects the 32-bit slice of the latched board state for a given write index.
module ai_wdata_mux
  import ai_pkg::*;
(
  input  logic [3:0]  idx_i,
  input  logic [99:0] fired_i,
  input  logic [99:0] hits_i,
  input  logic [4:0]  ships_i,
  output logic [31:0] wdata_o
);

  always_comb begin
    wdata_o = 32'd0;
    case (idx_i)
      ADDR_FIRED0: wdata_o = fired_i[31:0];
      ADDR_FIRED1: wdata_o = fired_i[63:32];
      ADDR_FIRED2: wdata_o = fired_i[95:64];
      ADDR_FIRED3: wdata_o = {28'd0, fired_i[99:96]};
      ADDR_HITS0:  wdata_o = hits_i[31:0];
      ADDR_HITS1:  wdata_o = hits_i[63:32];
      ADDR_HITS2:  wdata_o = hits_i[95:64];
      ADDR_HITS3:  wdata_o = {28'd0, hits_i[99:96]};
      ADDR_SHIPS:  wdata_o = {27'd0, ships_i};
      default:     wdata_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/ai_shot_seq.sv
// Sequences one AI move: uploads the board to the density engine, kicks it,
// waits (with a watchdog) and reads back the chosen cell index.
module ai_shot_seq
  import ai_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [99:0]          fired,
  input  logic [99:0]          hits,
  input  logic [4:0]           ships,
  output logic                 busy,
  output logic                 done,
  output logic [6:0]           shot_index,
  output logic                 error,
  ai_shot_seq_if.master        av
);

  state_t      state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic [99:0] fired_q, fired_d;
  logic [99:0] hits_q, hits_d;
  logic [4:0]  ships_q, ships_d;
  logic [9:0]  wdog_q, wdog_d;
  logic [6:0]  shot_q, shot_d;
  logic        err_q, err_d;
  logic [31:0] mux_wdata;
  logic [10:0] wdog_nxt;
  logic        timeout;
  logic        unused_rdata;

  ai_wdata_mux u_wdata_mux (
    .idx_i   (k_q),
    .fired_i (fired_q),
    .hits_i  (hits_q),
    .ships_i (ships_q),
    .wdata_o (mux_wdata)
  );

  // Counter is widened by one bit so the limit compare never wraps.
  assign wdog_nxt     = {1'b0, wdog_q} + 11'd1;
  assign timeout      = (wdog_nxt == 11'(TIMEOUT_CYC));
  assign unused_rdata = ^av.av_rdata[31:7];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= 4'd0;
      fired_q <= '0;
      hits_q  <= '0;
      ships_q <= '0;
      wdog_q  <= '0;
      shot_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      fired_q <= fired_d;
      hits_q  <= hits_d;
      ships_q <= ships_d;
      wdog_q  <= wdog_d;
      shot_q  <= shot_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    fired_d     = fired_q;
    hits_d      = hits_q;
    ships_d     = ships_q;
    wdog_d      = wdog_q;
    shot_d      = shot_q;
    err_d       = err_q;
    av.av_write = 1'b0;
    av.av_read  = 1'b0;
    av.av_addr  = ADDR_GO;
    av.av_wdata = 32'd0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          fired_d = fired;
          hits_d  = hits;
          ships_d = ships;
          k_d     = ADDR_FIRED0;
          state_d = WR;
        end
      end
      WR: begin
        av.av_write = 1'b1;
        av.av_addr  = k_q;
        av.av_wdata = mux_wdata;
        if (!av.av_waitreq) begin
          if (k_q == ADDR_SHIPS) begin
            wdog_d  = '0;
            state_d = GO;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
      end
      GO, GAP, BUSY: begin
        av.av_write = (state_q == GO);
        wdog_d      = wdog_nxt[9:0];
        if (timeout) begin
          shot_d  = NO_SHOT;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (state_q == GO) begin
          if (!av.av_waitreq) state_d = GAP;
        end else if (!av.av_waitreq) begin
          // An engine that never raised its wait request needs no BUSY cycle.
          state_d = RD;
        end else begin
          state_d = BUSY;
        end
      end
      RD: begin
        av.av_read = 1'b1;
        av.av_addr = ADDR_GO;
        shot_d     = av.av_rdata[6:0];
        err_d      = (av.av_rdata[6:0] > 7'(BOARD_CELLS - 1));
        state_d    = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign shot_index = shot_q;
  assign error      = err_q;

endmodule

// File: tb/tb_ai_shot_seq.sv
// Directed, table-driven bench for ai_shot_seq with a small engine model.
module tb_ai_shot_seq;

  typedef struct {
    logic [99:0] f;
    logic [99:0] h;
    logic [4:0]  s;
    logic [31:0] rd;
    int          hold;
    bit          hang;
    logic [6:0]  exp_shot;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [99:0] fired;
  logic [99:0] hits;
  logic [4:0]  ships;
  logic        busy;
  logic        done;
  logic [6:0]  shot_index;
  logic        error;
  logic [31:0] rdata_v;
  logic        waitreq_v;

  ai_shot_seq_if av();
  assign av.av_rdata   = rdata_v;
  assign av.av_waitreq = waitreq_v;

  ai_shot_seq #(.TIMEOUT_CYC(1023)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .fired      (fired),
    .hits       (hits),
    .ships      (ships),
    .busy       (busy),
    .done       (done),
    .shot_index (shot_index),
    .error      (error),
    .av         (av)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          both_bad = 0;
  int          stab_bad = 0;
  int          stall1 = 0;
  int          n_wr = 0;
  bit          go_acc = 1'b0;
  bit          prev_stall = 1'b0;
  logic [3:0]  p_addr;
  logic [31:0] p_data;
  logic [3:0]  wr_a [16];
  logic [31:0] wr_d [16];
  vec_t        vecs [9];
  vec_t        vfresh;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_wd(input logic [3:0] a, input logic [99:0] f,
                                         input logic [99:0] h, input logic [4:0] s);
    case (a)
      4'd1:    return f[31:0];
      4'd2:    return f[63:32];
      4'd3:    return f[95:64];
      4'd4:    return {28'd0, f[99:96]};
      4'd5:    return h[31:0];
      4'd6:    return h[63:32];
      4'd7:    return h[95:64];
      4'd8:    return {28'd0, h[99:96]};
      4'd9:    return {27'd0, s};
      default: return 32'd0;
    endcase
  endfunction

  // Observe the bus mid-cycle, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clock);
    if (av.av_write && av.av_read) both_bad++;
    if (prev_stall && (av.av_addr !== p_addr || av.av_wdata !== p_data || av.av_write !== 1'b1))
      stab_bad++;
    prev_stall = av.av_write && av.av_waitreq;
    p_addr     = av.av_addr;
    p_data     = av.av_wdata;
    if (av.av_write && av.av_waitreq && av.av_addr == 4'd1) stall1++;
    if (av.av_write && !av.av_waitreq) begin
      if (n_wr < 16) begin
        wr_a[4'(n_wr)] = av.av_addr;
        wr_d[4'(n_wr)] = av.av_wdata;
      end
      n_wr++;
      if (av.av_addr == 4'd0) go_acc = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run(input vec_t v, input string tag);
    int cyc;
    logic [3:0] ea;
    fired     = v.f;
    hits      = v.h;
    ships     = v.s;
    rdata_v   = v.rd;
    n_wr      = 0;
    go_acc    = 1'b0;
    stall1    = 0;
    waitreq_v = (v.hold > 0);
    start     = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    if (cyc > v.hold) waitreq_v = 1'b0;
    while (!done && cyc < 1200) begin
      tick();
      cyc++;
      if (cyc > v.hold) waitreq_v = 1'b0;
      if (v.hang && go_acc) waitreq_v = 1'b1;
    end
    chk({tag, "_cycles"}, 128'(cyc), 128'(v.exp_cyc));
    chk({tag, "_nwrites"}, 128'(n_wr), 128'(10));
    for (int i = 0; i < 10; i++) begin
      ea = (i < 9) ? 4'(i + 1) : 4'd0;
      chk({tag, "_write"}, 128'({wr_a[4'(i)], wr_d[4'(i)]}),
          128'({ea, exp_wd(ea, v.f, v.h, v.s)}));
    end
    chk({tag, "_shot"}, 128'(shot_index), 128'(v.exp_shot));
    chk({tag, "_err"}, 128'(error), 128'(v.exp_err));
    chk({tag, "_stall1"}, 128'(stall1), 128'(v.hold));
    waitreq_v = 1'b0;
    tick();
    chk({tag, "_done_pulse"}, 128'(done), 128'(0));
    chk({tag, "_busy_drop"}, 128'(busy), 128'(0));
    chk({tag, "_shot_held"}, 128'(shot_index), 128'(v.exp_shot));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_error"}, 128'(error), 128'(0));
    chk({tag, "_shot"}, 128'(shot_index), 128'(0));
    chk({tag, "_write"}, 128'(av.av_write), 128'(0));
    chk({tag, "_read"}, 128'(av.av_read), 128'(0));
    chk({tag, "_addr"}, 128'(av.av_addr), 128'(0));
    chk({tag, "_wdata"}, 128'(av.av_wdata), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0] = '{f: {4'h5, 32'h0, 32'h0, 32'h8000_0001}, h: 100'd0, s: 5'h11, rd: 32'd63,
                hold: 20, hang: 1'b0, exp_shot: 7'd63, exp_err: 1'b0, exp_cyc: 33};
    vecs[1] = '{f: 100'd0, h: 100'd0, s: 5'h1F, rd: 32'd44,
                hold: 0, hang: 1'b0, exp_shot: 7'd44, exp_err: 1'b0, exp_cyc: 13};
    vecs[2] = '{f: 100'd1 << 37, h: 100'd1 << 37, s: 5'h1E, rd: 32'd10,
                hold: 0, hang: 1'b0, exp_shot: 7'd10, exp_err: 1'b0, exp_cyc: 13};
    vecs[3] = '{f: 100'd0, h: 100'd0, s: 5'h03, rd: 32'd112,
                hold: 0, hang: 1'b0, exp_shot: 7'd112, exp_err: 1'b1, exp_cyc: 13};
    vecs[4] = '{f: 100'd3, h: 100'd0, s: 5'h01, rd: 32'd99,
                hold: 0, hang: 1'b0, exp_shot: 7'd99, exp_err: 1'b0, exp_cyc: 13};
    vecs[5] = '{f: 100'd0, h: 100'd4, s: 5'h01, rd: 32'd100,
                hold: 0, hang: 1'b0, exp_shot: 7'd100, exp_err: 1'b1, exp_cyc: 13};
    vecs[6] = '{f: 100'd0, h: 100'd0, s: 5'h10, rd: 32'hABCD_EF85,
                hold: 0, hang: 1'b0, exp_shot: 7'd5, exp_err: 1'b0, exp_cyc: 13};
    vecs[7] = '{f: {4'h9, 32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D},
                h: {4'h6, 32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F}, s: 5'h0A, rd: 32'd0,
                hold: 3, hang: 1'b0, exp_shot: 7'd0, exp_err: 1'b0, exp_cyc: 16};
    vecs[8] = '{f: 100'd7, h: 100'd0, s: 5'h1F, rd: 32'd44,
                hold: 0, hang: 1'b1, exp_shot: 7'd127, exp_err: 1'b1, exp_cyc: 1033};
    vfresh  = '{f: {4'hF, 32'h0000_FFFF, 32'h5555_AAAA, 32'h0102_0304},
                h: {4'h1, 32'h0, 32'h8000_0000, 32'h0}, s: 5'h07, rd: 32'd77,
                hold: 0, hang: 1'b0, exp_shot: 7'd77, exp_err: 1'b0, exp_cyc: 13};

    reset     = 1'b1;
    start     = 1'b0;
    fired     = '1;
    hits      = '1;
    ships     = '1;
    rdata_v   = 32'd0;
    waitreq_v = 1'b1;
    repeat (3) tick();
    chk_reset_outs("reset");

    reset = 1'b0;
    repeat (20) tick();
    chk("cold_idle_busy", 128'(busy), 128'(0));
    chk("cold_idle_write", 128'(av.av_write), 128'(0));

    for (int i = 0; i < 9; i++) begin
      run(vecs[4'(i)], $sformatf("vec%0d", i));
      if (i == 2) begin
        chk("hit37_addr5_data", 128'(wr_d[4]), 128'(32'h0000_0000));
        chk("hit37_addr6_data", 128'(wr_d[5]), 128'(32'h0000_0020));
        chk("fire37_addr2_data", 128'(wr_d[1]), 128'(32'h0000_0020));
      end
    end

    // Abandon a transfer while the engine is still computing.
    fired     = 100'd9;
    hits      = 100'd0;
    ships     = 5'h1F;
    n_wr      = 0;
    go_acc    = 1'b0;
    waitreq_v = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) begin
      tick();
      if (go_acc) waitreq_v = 1'b1;
    end
    chk("midbusy_pre_busy", 128'(busy), 128'(1));
    chk("midbusy_pre_write", 128'(av.av_write), 128'(0));
    #3 reset = 1'b1;
    #1;
    chk_reset_outs("midbusy_reset");
    @(posedge clock);
    #1;
    reset     = 1'b0;
    waitreq_v = 1'b0;
    tick();
    run(vfresh, "fresh");

    chk("no_rd_wr_overlap", 128'(both_bad), 128'(0));
    chk("stall_hold_stable", 128'(stab_bad), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
